// File: rtl/ring_sequence_monitor.sv
// Watches a one-hot rotate-right ring counter: encodes the hot bit to a phase,
// counts revolutions and latches sticky flags on multi-hot or out-of-order patterns.
//
// state  | meaning
// SYNC   | waiting for the first one-hot pattern to lock onto
// LOCKED | tracking rotation, phase valid
// FAULT  | error seen, samples ignored until err_clr or clear
module ring_sequence_monitor #(
  parameter int W  = 4,
  parameter int PW = 2,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          sample_en,
  input  logic [W-1:0]  ring_in,
  input  logic          err_clr,
  output logic [PW-1:0] phase,
  output logic          phase_valid,
  output logic [CW-1:0] rev_count,
  output logic          rev_pulse,
  output logic          illegal_err,
  output logic          seq_err
);

  typedef enum logic [1:0] {SYNC, LOCKED, FAULT} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] phase_nxt, idx, succ;
  logic [CW-1:0] rev_nxt;
  logic          pulse_nxt, ill_nxt, seq_nxt;
  logic          is_zero, is_legal;

  // A nonzero value with no bit left after clearing its lowest set bit is one-hot.
  assign is_zero  = ~|ring_in;
  assign is_legal = !is_zero && ((ring_in & (ring_in - W'(1))) == '0);
  assign succ     = (phase == '0) ? PW'(W - 1) : phase - PW'(1);

  always_comb begin
    idx = '0;
    for (int i = 0; i < W; i++) begin
      if (ring_in[i]) idx = PW'(i);
    end
  end

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    rev_nxt   = rev_count;
    pulse_nxt = 1'b0;
    ill_nxt   = illegal_err;
    seq_nxt   = seq_err;
    if (err_clr) begin
      state_nxt = SYNC;
      ill_nxt   = 1'b0;
      seq_nxt   = 1'b0;
    end else if (sample_en) begin
      case (state)
        SYNC: begin
          if (is_legal) begin
            state_nxt = LOCKED;
            phase_nxt = idx;
          end else if (!is_zero) begin
            state_nxt = FAULT;
            ill_nxt   = 1'b1;
          end
        end
        LOCKED: begin
          if (is_zero) begin
            state_nxt = SYNC;
          end else if (!is_legal) begin
            state_nxt = FAULT;
            ill_nxt   = 1'b1;
          end else if (idx == succ) begin
            phase_nxt = idx;
            if (idx == '0) begin
              rev_nxt   = rev_count + CW'(1);
              pulse_nxt = 1'b1;
            end
          end else if (idx != phase) begin
            state_nxt = FAULT;
            seq_nxt   = 1'b1;
          end
        end
        FAULT:   state_nxt = FAULT;
        default: state_nxt = SYNC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state       <= SYNC;
      phase       <= '0;
      phase_valid <= 1'b0;
      rev_count   <= '0;
      rev_pulse   <= 1'b0;
      illegal_err <= 1'b0;
      seq_err     <= 1'b0;
    end else begin
      state       <= state_nxt;
      phase       <= phase_nxt;
      phase_valid <= (state_nxt == LOCKED);
      rev_count   <= rev_nxt;
      rev_pulse   <= pulse_nxt;
      illegal_err <= ill_nxt;
      seq_err     <= seq_nxt;
    end
  end

endmodule

// File: tb/tb_ring_sequence_monitor.sv
// Bench for ring_sequence_monitor: a CW=8 and a CW=2 instance share stimulus and are
// compared every cycle against a rule-level model of the ring checker.
module tb_ring_sequence_monitor;

  logic       clk = 1'b0;
  logic       clear, sample_en, err_clr;
  logic [3:0] ring_in;

  logic [1:0] a_phase, b_phase;
  logic [7:0] a_rev;
  logic [1:0] b_rev;
  logic       a_valid, a_pulse, a_ill, a_seq;
  logic       b_valid, b_pulse, b_ill, b_seq;

  int checks = 0;
  int failures = 0;

  localparam int M_SYNC = 0, M_LOCKED = 1, M_FAULT = 2;
  int m_state, e_phase, e_rev;
  bit e_pulse, e_ill, e_seq;

  always #5 clk = ~clk;

  ring_sequence_monitor #(.W(4), .PW(2), .CW(8)) u_dut_a (
    .clk(clk), .clear(clear), .sample_en(sample_en), .ring_in(ring_in), .err_clr(err_clr),
    .phase(a_phase), .phase_valid(a_valid), .rev_count(a_rev), .rev_pulse(a_pulse),
    .illegal_err(a_ill), .seq_err(a_seq)
  );

  ring_sequence_monitor #(.W(4), .PW(2), .CW(2)) u_dut_b (
    .clk(clk), .clear(clear), .sample_en(sample_en), .ring_in(ring_in), .err_clr(err_clr),
    .phase(b_phase), .phase_valid(b_valid), .rev_count(b_rev), .rev_pulse(b_pulse),
    .illegal_err(b_ill), .seq_err(b_seq)
  );

  wire logic [21:0] obs = {a_phase, a_valid, a_rev, a_pulse, a_ill, a_seq,
                           b_phase, b_valid, b_rev, b_pulse, b_ill, b_seq};

  function automatic logic [21:0] exp_vec();
    logic v;
    v = (m_state == M_LOCKED);
    return {2'(e_phase), v, 8'(e_rev), e_pulse, e_ill, e_seq,
            2'(e_phase), v, 2'(e_rev), e_pulse, e_ill, e_seq};
  endfunction

  // Apply one cycle of inputs and advance the model by the checker's rules.
  task automatic drive(input bit c, input bit ec, input bit se, input logic [3:0] r);
    int k;
    clear = c; err_clr = ec; sample_en = se; ring_in = r;
    @(posedge clk);
    e_pulse = 0;
    if (c) begin
      m_state = M_SYNC; e_phase = 0; e_rev = 0; e_ill = 0; e_seq = 0;
    end else if (ec) begin
      m_state = M_SYNC; e_ill = 0; e_seq = 0;
    end else if (se && m_state != M_FAULT) begin
      if ($countones(r) >= 2) begin
        m_state = M_FAULT; e_ill = 1;
      end else if ($countones(r) == 1) begin
        k = $clog2(r);
        if (m_state == M_SYNC) begin
          m_state = M_LOCKED; e_phase = k;
        end else if (k == (e_phase + 3) % 4) begin
          e_phase = k;
          if (k == 0) begin e_rev++; e_pulse = 1; end
        end else if (k != e_phase) begin
          m_state = M_FAULT; e_seq = 1;
        end
      end else if (m_state == M_LOCKED) begin
        m_state = M_SYNC;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 4'b0000);
    checks++;
    if (obs !== 22'd0) begin
      failures++;
      $display("FAIL reset: got %h want %h", obs, 22'd0);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] pat [5] = '{4'b0001, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
    int ph [5] = '{0, 3, 2, 1, 0};
    drive(1, 0, 0, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1, pat[i]);
      checks++;
      if (obs !== exp_vec() || a_phase !== 2'(ph[i]) || a_valid !== 1'b1) begin
        failures++;
        $display("FAIL rotation step %0d: got %h want %h (phase %0d want %0d)",
                 i, obs, exp_vec(), a_phase, ph[i]);
      end
    end
    checks++;
    if (a_rev !== 8'd1 || a_pulse !== 1'b1) begin
      failures++;
      $display("FAIL rotation rev: got rev=%0d pulse=%b want rev=1 pulse=1", a_rev, a_pulse);
    end
    drive(0, 0, 0, 4'b0001);
    checks++;
    if (a_pulse !== 1'b0 || obs !== exp_vec()) begin
      failures++;
      $display("FAIL rotation pulse width: got %h want %h", obs, exp_vec());
    end
  endtask

  task automatic test_hold();
    logic [3:0] pat [10] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001,
                             4'b1000, 4'b0100, 4'b0010, 4'b0001};
    drive(1, 0, 0, 4'b0000);
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 1, pat[i]);
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL hold step %0d: got %h want %h", i, obs, exp_vec());
      end
    end
    checks++;
    if (a_rev !== 8'd1 || a_ill !== 1'b0 || a_seq !== 1'b0) begin
      failures++;
      $display("FAIL hold end: got rev=%0d ill=%b seq=%b want rev=1 ill=0 seq=0", a_rev, a_ill, a_seq);
    end
  endtask

  task automatic test_seq_err();
    logic [3:0] pat [6] = '{4'b0001, 4'b1000, 4'b0010, 4'b0001, 4'b0110, 4'b0100};
    drive(1, 0, 0, 4'b0000);
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 1, pat[i]);
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL seq_err step %0d: got %h want %h", i, obs, exp_vec());
      end
    end
    checks++;
    if (a_seq !== 1'b1 || a_valid !== 1'b0 || a_phase !== 2'd3 || a_ill !== 1'b0) begin
      failures++;
      $display("FAIL seq_err flag: got seq=%b valid=%b phase=%0d ill=%b want 1 0 3 0",
               a_seq, a_valid, a_phase, a_ill);
    end
    drive(0, 1, 0, 4'b0000);
    checks++;
    if (obs !== exp_vec() || a_seq !== 1'b0) begin
      failures++;
      $display("FAIL seq_err clear: got %h want %h", obs, exp_vec());
    end
  endtask

  task automatic test_illegal();
    drive(1, 0, 0, 4'b0000);
    drive(0, 0, 1, 4'b0110);
    checks++;
    if (obs !== exp_vec() || a_ill !== 1'b1 || a_valid !== 1'b0) begin
      failures++;
      $display("FAIL illegal flag: got %h want %h", obs, exp_vec());
    end
    drive(0, 1, 1, 4'b1001);
    checks++;
    if (obs !== exp_vec() || a_ill !== 1'b0 || a_seq !== 1'b0) begin
      failures++;
      $display("FAIL illegal clear: got %h want %h", obs, exp_vec());
    end
    drive(0, 0, 1, 4'b0100);
    checks++;
    if (obs !== exp_vec() || a_valid !== 1'b1 || a_phase !== 2'd2) begin
      failures++;
      $display("FAIL illegal relock: got %h want %h", obs, exp_vec());
    end
  endtask

  task automatic test_wrap();
    int pulses;
    pulses = 0;
    drive(1, 0, 0, 4'b0000);
    drive(0, 0, 1, 4'b0001);
    for (int i = 0; i < 257 * 4; i++) begin
      drive(0, 0, 1, 4'b0001 << ((3 - (i % 4)) % 4));
      if (b_pulse === 1'b1) pulses++;
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL wrap step %0d: got %h want %h", i, obs, exp_vec());
      end
    end
    checks++;
    if (pulses != 257 || a_rev !== 8'd1 || b_rev !== 2'd1 || a_ill !== 1'b0 || b_seq !== 1'b0) begin
      failures++;
      $display("FAIL wrap totals: got pulses=%0d rev8=%0d rev2=%0d want 257 1 1", pulses, a_rev, b_rev);
    end
  endtask

  task automatic test_clear_mid();
    drive(1, 0, 0, 4'b0000);
    drive(0, 0, 1, 4'b0001);
    drive(0, 0, 1, 4'b1000);
    drive(0, 0, 1, 4'b0100);
    checks++;
    if (a_phase !== 2'd2 || obs !== exp_vec()) begin
      failures++;
      $display("FAIL clear_mid setup: got %h want %h", obs, exp_vec());
    end
    drive(1, 1, 1, 4'b0010);
    checks++;
    if (obs !== 22'd0 || obs !== exp_vec()) begin
      failures++;
      $display("FAIL clear_mid: got %h want %h", obs, 22'd0);
    end
  endtask

  task automatic test_random();
    drive(1, 0, 0, 4'b0000);
    for (int i = 0; i < 600; i++) begin
      int roll;
      logic [3:0] r;
      roll = $urandom_range(0, 99);
      if (roll < 60)      r = 4'b0001 << ((e_phase + 3) % 4);
      else if (roll < 75) r = 4'b0001 << e_phase;
      else                r = 4'($urandom);
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 29) == 0,
            $urandom_range(0, 9) != 0, r);
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL random step %0d: got %h want %h", i, obs, exp_vec());
      end
    end
  endtask

  initial begin
    clear = 1'b1; err_clr = 1'b0; sample_en = 1'b0; ring_in = 4'b0000;
    m_state = M_SYNC; e_phase = 0; e_rev = 0; e_pulse = 0; e_ill = 0; e_seq = 0;
    test_reset();
    test_rotation();
    test_hold();
    test_seq_err();
    test_illegal();
    test_wrap();
    test_clear_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
